fetch_stage: RTL

Instruction-fetch stage directly upstream of the decode/control stage. It holds the PC, issues in-order word requests to instruction memory over a valid/ready handshake and buffers returned words in a small FIFO. It presents {instruction, pc} to decode with a valid/stall handshake. It handles taken-branch redirects from EX by flushing the buffer and discarding in-flight responses.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, credit-limited imem requests, response FIFO, redirect flush
// Optional saturating perf counters are built when FETCH_PERF_COUNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [3:0]    outstanding;
  logic [3:0]    drop_cnt;
  logic [3:0]    count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];

  logic          pop;
  logic          accept;
  logic          rsp_hit;
  logic [4:0]    credit_used;
  logic [3:0]    inflight;
  logic [3:0]    new_drop;
  logic [31:0]   redirect_aligned;
  logic [31:0]   rsp_tag;
  logic          unused_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_ok        = ^redirect_pc[1:0];
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  assign if_valid       = (count != 4'd0);
  assign if_instruction = if_valid ? buf_instr[rd_ptr] : 32'd0;
  assign if_pc          = if_valid ? buf_pc[rd_ptr] : 32'd0;

  assign pop         = if_valid && !stall;
  assign credit_used = {1'b0, outstanding} + {1'b0, count} - {4'b0, pop};
  assign imem_req    = (state == FETCH) && !redirect_valid && (credit_used < 5'(BUF_DEPTH));
  assign imem_addr   = pc;
  assign accept      = imem_req && imem_ready;

  // In-flight responses are tracked by outstanding in FETCH and by drop_cnt in FLUSH.
  assign inflight = (state == FLUSH) ? drop_cnt : outstanding;
  assign rsp_hit  = imem_rvalid && (inflight != 4'd0);
  assign new_drop = inflight - {3'b0, rsp_hit};

  // Requests are consecutive words, so the oldest outstanding one sits outstanding*4 behind pc.
  assign rsp_tag = pc - {26'd0, outstanding, 2'b00};

`ifdef FETCH_PERF_COUNT_EN
  logic        pop_fetch;
  logic [3:0]  flush_inc;
  logic [32:0] flushed_sum;

  assign pop_fetch   = (state == FETCH) && !redirect_valid && pop;
  assign flush_inc   = (redirect_valid && state != BOOT) ? count + {3'b0, rsp_hit} :
                       (state == FLUSH) ? {3'b0, rsp_hit} : 4'd0;
  assign flushed_sum = {1'b0, perf_flushed} + {29'd0, flush_inc};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      outstanding <= 4'd0;
      drop_cnt    <= 4'd0;
      count       <= 4'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
`ifdef FETCH_PERF_COUNT_EN
      perf_fetched <= 32'd0;
      perf_flushed <= 32'd0;
`endif
    end else begin
      if (state == BOOT) begin
        state <= FETCH;
        if (redirect_valid) pc <= redirect_aligned;
      end else if (redirect_valid) begin
        pc          <= redirect_aligned;
        count       <= 4'd0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        outstanding <= 4'd0;
        drop_cnt    <= new_drop;
        state       <= (new_drop != 4'd0) ? FLUSH : FETCH;
      end else if (state == FLUSH) begin
        if (rsp_hit) begin
          drop_cnt <= drop_cnt - 4'd1;
          if (drop_cnt == 4'd1) state <= FETCH;
        end
      end else begin
        if (accept) pc <= pc + 32'd4;
        outstanding <= outstanding + {3'b0, accept} - {3'b0, rsp_hit};
        if (rsp_hit) begin
          buf_instr[wr_ptr] <= imem_rdata;
          buf_pc[wr_ptr]    <= rsp_tag;
          wr_ptr            <= next_ptr(wr_ptr);
        end
        if (pop) rd_ptr <= next_ptr(rd_ptr);
        count <= count + {3'b0, rsp_hit} - {3'b0, pop};
      end
`ifdef FETCH_PERF_COUNT_EN
      if (pop_fetch && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
`endif
    end
  end

endmodule
